// File: rtl/pin_checker_pkg.sv
// +------------------------------------------------------------------+
// | pin_pkg : shared types and constants for the PIN checker          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package pin_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_COMPARE = 3'd2,
    ST_GRANTED = 3'd3,
    ST_LOCKED  = 3'd4
  } state_e;

  function automatic int digits_of(input int pin_w);
    return pin_w / DIGIT_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pin_checker_if.sv
// +------------------------------------------------------------------+
// | pin_checker_if : keypad/key-store side bundle of the PIN checker  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface pin_checker_if
  import pin_pkg::*;
#(
  parameter int PIN_W     = 16,
  parameter int MAX_TRIES = 3
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [PIN_W-1:0]   stored_pin_i;
  logic               key_empty_i;
  logic [DIGIT_W-1:0] digit_i;
  logic               digit_valid_i;
  logic               clear_i;
  logic               logout_i;
  logic               unlock_o;
  logic               fail_o;
  logic               locked_o;
  logic [TRY_W-1:0]   tries_left_o;
  logic [2:0]         digit_count_o;

  modport master (
    output stored_pin_i, key_empty_i, digit_i, digit_valid_i, clear_i, logout_i,
    input  unlock_o, fail_o, locked_o, tries_left_o, digit_count_o
  );

  modport slave (
    input  stored_pin_i, key_empty_i, digit_i, digit_valid_i, clear_i, logout_i,
    output unlock_o, fail_o, locked_o, tries_left_o, digit_count_o
  );

endinterface

`default_nettype wire

// File: rtl/pin_checker_lockout_timer.sv
// +------------------------------------------------------------------+
// | lockout_timer : LOCK_CYCLES down-counter, used with PIN_CHECKER_LOCKOUT_EN |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module lockout_timer #(
  parameter int LOCK_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  output logic done_o
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CNT_INIT;
    end else if (run_i && (count_q != '0)) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded with LOCK_CYCLES-1, so done lands on the LOCK_CYCLES-th running cycle.
  assign done_o = run_i && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/pin_checker.sv
// +------------------------------------------------------------------+
// | pin_checker : BCD PIN entry, compare, grant/deny, optional lockout |
// | Lockout enabled by PIN_CHECKER_LOCKOUT_EN.  Revision: 1.0          |
// +------------------------------------------------------------------+
`default_nettype none

module pin_checker
  import pin_pkg::*;
#(
  parameter int PIN_W       = 16,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pin_checker_if.slave  bus
);

  localparam int DIGITS = digits_of(PIN_W);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
  localparam logic [2:0]       CNT_LAST  = 3'(DIGITS - 1);

  if ((LOCK_CYCLES < 1) || (MAX_TRIES < 1) || (DIGITS < 1) || (DIGITS > 7)) begin : g_param_check
    $error("pin_checker: illegal parameter set");
  end

  state_e             state_q, state_d;
  logic [PIN_W-1:0]   entry_q, entry_d;
  logic [2:0]         count_q, count_d;
  logic               bad_q, bad_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               fail_q, fail_d;
  logic               accept;
  logic               match;

`ifdef PIN_CHECKER_LOCKOUT_EN
  logic lock_load;
  logic lock_done;

  lockout_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (lock_load),
    .run_i  (state_q == ST_LOCKED),
    .done_o (lock_done)
  );
`endif

  assign match = (entry_q == bus.stored_pin_i) && !bad_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      count_q <= '0;
      bad_q   <= 1'b0;
      tries_q <= TRIES_MAX;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      bad_q   <= bad_d;
      tries_q <= tries_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    bad_d   = bad_q;
    tries_d = tries_q;
    fail_d  = 1'b0;
    accept  = 1'b0;
`ifdef PIN_CHECKER_LOCKOUT_EN
    lock_load = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.digit_valid_i && !bus.key_empty_i) begin
          accept  = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Abort beats a simultaneous digit; nothing of the partial entry survives.
        if (bus.clear_i || bus.key_empty_i) begin
          state_d = ST_IDLE;
          entry_d = '0;
          count_d = '0;
          bad_d   = 1'b0;
        end else if (bus.digit_valid_i) begin
          accept = 1'b1;
        end
      end
      ST_COMPARE: begin
        entry_d = '0;
        count_d = '0;
        bad_d   = 1'b0;
        if (match) begin
          state_d = ST_GRANTED;
          tries_d = TRIES_MAX;
        end else begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef PIN_CHECKER_LOCKOUT_EN
          tries_d = tries_q - TRY_W'(1);
          if (tries_q == TRY_W'(1)) begin
            state_d   = ST_LOCKED;
            lock_load = 1'b1;
          end
`endif
        end
      end
      ST_GRANTED: begin
        if (bus.logout_i || bus.key_empty_i) begin
          state_d = ST_IDLE;
        end
      end
`ifdef PIN_CHECKER_LOCKOUT_EN
      ST_LOCKED: begin
        if (lock_done) begin
          state_d = ST_IDLE;
          tries_d = TRIES_MAX;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      entry_d = {entry_q[PIN_W-DIGIT_W-1:0], bus.digit_i};
      count_d = count_q + 3'd1;
      if (bus.digit_i > DIGIT_MAX) begin
        bad_d = 1'b1;
      end
      if (count_q == CNT_LAST) begin
        state_d = ST_COMPARE;
      end
    end
  end

  always_comb begin
    bus.unlock_o      = (state_q == ST_GRANTED);
    bus.fail_o        = fail_q;
    bus.tries_left_o  = tries_q;
    bus.digit_count_o = count_q;
`ifdef PIN_CHECKER_LOCKOUT_EN
    bus.locked_o      = (state_q == ST_LOCKED);
`else
    bus.locked_o      = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_pin_checker.sv
// +------------------------------------------------------------------+
// | tb_pin_checker : vector table, corner sequences, random vs model  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pin_checker;

  localparam int PIN_W       = 16;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 20;
  localparam int DIGITS      = PIN_W / 4;
`ifdef PIN_CHECKER_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int T_A = LOCK_EN ? 2 : 3;
  localparam int T_B = LOCK_EN ? 1 : 3;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pin_checker_if #(.PIN_W(PIN_W), .MAX_TRIES(MAX_TRIES)) bus ();

  pin_checker #(
    .PIN_W       (PIN_W),
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the entry as a list of digits plus a few status flags.
  int  m_q[$];
  bit  m_granted;
  bit  m_comparing;
  int  m_lock_rem;
  int  m_tries;
  bit  m_fail;

  task automatic model_reset();
    m_q.delete();
    m_granted   = 1'b0;
    m_comparing = 1'b0;
    m_lock_rem  = 0;
    m_tries     = MAX_TRIES;
    m_fail      = 1'b0;
  endtask

  task automatic model_step();
    logic [PIN_W-1:0] val;
    bit ok;
    m_fail = 1'b0;
    if (m_lock_rem > 0) begin
      m_lock_rem--;
      if (m_lock_rem == 0) m_tries = MAX_TRIES;
    end else if (m_granted) begin
      if (bus.logout_i || bus.key_empty_i) m_granted = 1'b0;
    end else if (m_comparing) begin
      m_comparing = 1'b0;
      val = '0;
      ok  = 1'b1;
      foreach (m_q[i]) begin
        val = (val << 4) | PIN_W'(m_q[i]);
        if (m_q[i] > 9) ok = 1'b0;
      end
      m_q.delete();
      if (ok && (val == bus.stored_pin_i)) begin
        m_granted = 1'b1;
        m_tries   = MAX_TRIES;
      end else begin
        m_fail = 1'b1;
        if (LOCK_EN) begin
          m_tries--;
          if (m_tries == 0) m_lock_rem = LOCK_CYCLES;
        end
      end
    end else if (m_q.size() == 0) begin
      if (bus.digit_valid_i && !bus.key_empty_i) m_q.push_back(int'(bus.digit_i));
      if (m_q.size() == DIGITS) m_comparing = 1'b1;
    end else begin
      if (bus.clear_i || bus.key_empty_i) m_q.delete();
      else if (bus.digit_valid_i) m_q.push_back(int'(bus.digit_i));
      if (m_q.size() == DIGITS) m_comparing = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model();
    chk("model_unlock", 32'(bus.unlock_o), 32'(m_granted));
    chk("model_fail",   32'(bus.fail_o),   32'(m_fail));
    chk("model_locked", 32'(bus.locked_o), 32'(m_lock_rem > 0));
    chk("model_tries",  32'(bus.tries_left_o), 32'(m_tries));
    chk("model_count",  32'(bus.digit_count_o), 32'(m_q.size()));
  endtask

  task automatic drive(input bit dv, input logic [3:0] d, input bit clr, input bit lo, input bit emp);
    bus.digit_valid_i = dv;
    bus.digit_i       = d;
    bus.clear_i       = clr;
    bus.logout_i      = lo;
    bus.key_empty_i   = emp;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check_model();
  endtask

  task automatic enter(input logic [PIN_W-1:0] pin);
    for (int i = 0; i < DIGITS; i++) begin
      drive(1'b1, 4'(pin >> (4 * (DIGITS - 1 - i))), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  typedef struct {
    bit         dv;
    logic [3:0] d;
    bit         clr;
    bit         lo;
    bit         emp;
    bit         e_unl;
    bit         e_fail;
    int         e_tries;
    int         e_cnt;
  } vec_t;

  function automatic vec_t v(input bit dv, input int d, input bit clr, input bit lo, input bit emp,
                             input bit e_unl, input bit e_fail, input int e_tries, input int e_cnt);
    vec_t r;
    r.dv = dv; r.d = 4'(d); r.clr = clr; r.lo = lo; r.emp = emp;
    r.e_unl = e_unl; r.e_fail = e_fail; r.e_tries = e_tries; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    int   n;
    int   fails;
    bit   any_lock;
    logic [PIN_W-1:0] stored;

    // correct entry, granted, digits ignored, logout
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 3, 2));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, 3, 3));
    tbl.push_back(v(1, 4, 0, 0, 0, 0, 0, 3, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 3, 0));
    tbl.push_back(v(1, 5, 0, 0, 0, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 3, 0));
    // clear wins over a simultaneous digit
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 3, 2));
    tbl.push_back(v(1, 3, 1, 0, 0, 0, 0, 3, 0));
    // wrong last digit
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, 3, 2));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, 3, 3));
    tbl.push_back(v(1, 5, 0, 0, 0, 0, 0, 3, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, T_A, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, T_A, 0));
    // empty key store ignores digits
    tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, T_A, 0));
    // non-BCD digit forces a mismatch
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, T_A, 1));
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, T_A, 2));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, T_A, 3));
    tbl.push_back(v(1, 10, 0, 0, 0, 0, 0, T_A, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, T_B, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, T_B, 0));
    // correct entry restores tries
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, T_B, 1));
    tbl.push_back(v(1, 2, 0, 0, 0, 0, 0, T_B, 2));
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 0, T_B, 3));
    tbl.push_back(v(1, 4, 0, 0, 0, 0, 0, T_B, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 3, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 3, 0));

    rst_i = 1'b1;
    bus.stored_pin_i = 16'h1234;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #22;
    chk("reset_unlock", 32'(bus.unlock_o), 32'd0);
    chk("reset_fail",   32'(bus.fail_o), 32'd0);
    chk("reset_locked", 32'(bus.locked_o), 32'd0);
    chk("reset_tries",  32'(bus.tries_left_o), 32'(MAX_TRIES));
    chk("reset_count",  32'(bus.digit_count_o), 32'd0);
    rst_i = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].dv, tbl[i].d, tbl[i].clr, tbl[i].lo, tbl[i].emp);
      tick();
      chk($sformatf("vec%0d_unlock", i), 32'(bus.unlock_o), 32'(tbl[i].e_unl));
      chk($sformatf("vec%0d_fail", i),   32'(bus.fail_o), 32'(tbl[i].e_fail));
      chk($sformatf("vec%0d_locked", i), 32'(bus.locked_o), 32'd0);
      chk($sformatf("vec%0d_tries", i),  32'(bus.tries_left_o), 32'(tbl[i].e_tries));
      chk($sformatf("vec%0d_count", i),  32'(bus.digit_count_o), 32'(tbl[i].e_cnt));
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef PIN_CHECKER_LOCKOUT_EN
    // three wrong entries lock out for exactly LOCK_CYCLES cycles
    for (int k = 0; k < MAX_TRIES; k++) enter(16'h4321);
    chk("lock_rise", 32'(bus.locked_o), 32'd1);
    chk("lock_tries0", 32'(bus.tries_left_o), 32'd0);
    n = 1;
    while (bus.locked_o && n < 100) begin
      drive(1'b1, 4'($urandom_range(0, 9)), 1'b0, 1'b0, 1'b0);
      tick();
      chk("lock_count_frozen", 32'(bus.digit_count_o), 32'd0);
      if (bus.locked_o) n++;
    end
    chk("lock_length", 32'(n), 32'(LOCK_CYCLES));
    chk("lock_reload", 32'(bus.tries_left_o), 32'(MAX_TRIES));
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    enter(16'h1234);
    chk("post_lock_unlock", 32'(bus.unlock_o), 32'd1);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a lockout
    for (int k = 0; k < MAX_TRIES; k++) enter(16'h9999);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_lock_locked", 32'(bus.locked_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_lock_locked", 32'(bus.locked_o), 32'd0);
    chk("rst_lock_tries",  32'(bus.tries_left_o), 32'(MAX_TRIES));
    chk("rst_lock_count",  32'(bus.digit_count_o), 32'd0);
    model_reset();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
`else
    // without lockout every wrong entry just pulses fail
    fails    = 0;
    any_lock = 1'b0;
    for (int k = 0; k < 5; k++) begin
      enter(16'h5678);
      if (bus.fail_o) fails++;
      if (bus.locked_o) any_lock = 1'b1;
      tick();
      if (bus.fail_o) fails++;
    end
    chk("nolock_fail_pulses", 32'(fails), 32'd5);
    chk("nolock_never_locked", 32'(any_lock), 32'd0);
    chk("nolock_tries", 32'(bus.tries_left_o), 32'(MAX_TRIES));
`endif

    // random traffic against the model
    stored = 16'h1234;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] d;
      if (c % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: stored = 16'h1234;
          1: stored = 16'h0000;
          2: stored = 16'h9999;
          default: stored = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
        bus.stored_pin_i = stored;
      end
      if ((m_q.size() < DIGITS) && ($urandom_range(0, 9) < 7))
        d = 4'(stored >> (4 * (DIGITS - 1 - m_q.size())));
      else
        d = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 9) < 6, d, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 32) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
